reg_access_ctrl: RTL

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_access_ctrl_if.sv | 33 +++
 rtl/reg_access_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/reg_access_ctrl_if.sv
// Command/response bus plus register-bank strobe lines for reg_access_ctrl.
// The master side drives the commands and presents the register outputs.
interface reg_access_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
);
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic                           cmd_write;
  logic [ADDR_WIDTH-1:0]          cmd_addr;
  logic [DATA_WIDTH-1:0]          cmd_wdata;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [DATA_WIDTH-1:0]          rsp_rdata;
  logic                           rsp_err;
  logic [NUM_REGS-1:0]            reg_write_flag;
  logic [NUM_REGS-1:0]            reg_read_flag;
  logic [DATA_WIDTH-1:0]          reg_data_in;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data_out;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, reg_data_out,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           reg_write_flag, reg_read_flag, reg_data_in
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, reg_data_out,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           reg_write_flag, reg_read_flag, reg_data_in
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Single-outstanding register access controller: turns one command into a
// one-cycle register strobe and returns a held response.
module reg_access_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic              SYS_CLK,
  input  logic              rst,
  reg_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic [NUM_REGS-1:0]   r_wr_flag;
  logic [NUM_REGS-1:0]   r_rd_flag;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_in_range;
  logic [NUM_REGS-1:0]   w_onehot;
  logic [DATA_WIDTH-1:0] w_rd_slice;

  assign w_in_range = 32'(bus.cmd_addr) < NUM_REGS;
  assign w_onehot   = NUM_REGS'(1) << bus.cmd_addr;

  always_comb begin
    w_rd_slice = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(r_addr) == i) w_rd_slice = bus.reg_data_out[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Strobes are set on the accepting edge so they are high exactly during ISSUE.
  always_ff @(posedge SYS_CLK or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_wr_flag   <= '0;
      r_rd_flag   <= '0;
      r_data_in   <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_write     <= bus.cmd_write;
            r_addr      <= bus.cmd_addr;
            if (w_in_range) begin
              r_state <= ISSUE;
              if (bus.cmd_write) begin
                r_wr_flag <= w_onehot;
                r_data_in <= bus.cmd_wdata;
              end else begin
                r_rd_flag <= w_onehot;
              end
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end
          end
        end
        ISSUE: begin
          r_wr_flag <= '0;
          r_rd_flag <= '0;
          if (r_write) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_rd_slice;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.rsp_err        = r_rsp_err;
  assign bus.reg_write_flag = r_wr_flag;
  assign bus.reg_read_flag  = r_rd_flag;
  assign bus.reg_data_in    = r_data_in;

endmodule
